// File: rtl/hex_disp_arbiter.sv
// Two-requester arbiter for a 4-digit seven-segment display: round-robin
// grant with a minimum hold time, and one shared decoder refreshing one digit per clock.
module hex_disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    output logic [1:0]  gnt,
    output logic [7:0]  hex3,
    output logic [7:0]  hex2,
    output logic [7:0]  hex1,
    output logic [7:0]  hex0,
    output logic        busy
);

    localparam logic [31:0] HOLD_MAX = HOLD_CYCLES - 32'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;
    logic [1:0]  r_idx;
    logic        r_ptr;
    logic [1:0]  r_gnt;
    logic [7:0]  r_hex [4];

    logic        w_hold_done;
    logic        w_change;
    logic [15:0] w_data;
    logic [3:0]  w_dps;
    logic [3:0]  w_nib;
    logic        w_dp;
    logic [7:0]  w_seg;

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        cnt_sat_inc = (c >= HOLD_MAX) ? HOLD_MAX : c + 32'd1;
    endfunction

    assign w_hold_done = (r_cnt == HOLD_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req == 2'b01)      w_next = OWN0;
                else if (req == 2'b10) w_next = OWN1;
                else if (req == 2'b11) w_next = r_ptr ? OWN1 : OWN0;
            end
            OWN0: begin
                if (!req[0])                    w_next = req[1] ? OWN1 : IDLE;
                else if (req[1] && w_hold_done) w_next = OWN1;
            end
            OWN1: begin
                if (!req[1])                    w_next = req[0] ? OWN0 : IDLE;
                else if (req[0] && w_hold_done) w_next = OWN0;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_change = (w_next != r_state);

    // Single shared decoder: the owner's nibble for the current digit index.
    assign w_data = (r_state == OWN1) ? data1 : data0;
    assign w_dps  = (r_state == OWN1) ? dp1 : dp0;
    assign w_nib  = w_data[{r_idx, 2'b00} +: 4];
    assign w_dp   = w_dps[r_idx];
    assign w_seg  = {~w_dp, seg7(w_nib)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_cnt   <= 32'd0;
            r_idx   <= 2'd0;
            r_ptr   <= 1'b0;
            for (int k = 0; k < 4; k++) r_hex[k] <= 8'hFF;
        end else begin
            r_state <= w_next;
            case (w_next)
                OWN0:    r_gnt <= 2'b01;
                OWN1:    r_gnt <= 2'b10;
                default: r_gnt <= 2'b00;
            endcase

            if (w_change || (w_next == IDLE)) begin
                r_cnt <= 32'd0;
                r_idx <= 2'd0;
            end else begin
                r_cnt <= cnt_sat_inc(r_cnt);
                r_idx <= r_idx + 2'd1;
            end

            // Pointer always aims at the requester that did not just win.
            if (w_change && (w_next == OWN0))      r_ptr <= 1'b1;
            else if (w_change && (w_next == OWN1)) r_ptr <= 1'b0;

            if (w_next == IDLE) begin
                for (int k = 0; k < 4; k++) r_hex[k] <= 8'hFF;
            end else if (r_state != IDLE) begin
                r_hex[r_idx] <= w_seg;
            end
        end
    end

    assign gnt  = r_gnt;
    assign busy = |r_gnt;
    assign hex0 = r_hex[0];
    assign hex1 = r_hex[1];
    assign hex2 = r_hex[2];
    assign hex3 = r_hex[3];

endmodule

// File: doc/hex_disp_arbiter.md
HEX_DISP_ARBITER -- requirements
Module: hex_disp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 50_000_000: minimum cycles an owner keeps the display before it can be preempted (1 s at 50 MHz); legal range 2..2^32-1.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  req[i] high = requester i wants the display; level-sensitive.
REQ-005 data0, data1  input  16 each  hex value of requester i; nibble k drives digit k.
REQ-006 dp0, dp1  input  4 each  decimal-point enable per digit for requester i; 1 = lit.
REQ-007 gnt  output  2  one-hot grant; 2'b00 = no owner; registered.
REQ-008 hex3, hex2, hex1, hex0  output  8 each  active-low segment patterns, bit7 = dp, bits6:0 = g..a; registered.
REQ-009 busy  output  1  high whenever gnt != 0.

Function
REQ-010 FSM states: IDLE, OWN0, OWN1; gnt = 01 in OWN0, 10 in OWN1, 00 in IDLE; gnt is never 11.
REQ-011 IDLE: exactly one req bit high -> grant that requester next cycle (latency 1).
REQ-012 IDLE with req = 11 -> grant the requester not granted last (round-robin pointer); after reset the pointer favours requester 0.
REQ-013 OWNi: hold counter starts at 0 on grant entry and increments by 1 per cycle; it saturates at HOLD_CYCLES-1.
REQ-014 OWNi with req[i] low -> IDLE next cycle, unless req[1-i] is high, in which case go directly to OWN(1-i).
REQ-015 OWNi with req[i] high, req[1-i] high and counter = HOLD_CYCLES-1 -> OWN(1-i) next cycle (preemption); the counter restarts at 0.
REQ-016 OWNi with req[i] high and counter < HOLD_CYCLES-1: stay in OWNi regardless of req[1-i].
REQ-017 The round-robin pointer updates on every grant to point away from the new owner.
REQ-018 A single shared 4-bit hex-to-segment decoder is used (one instance only); a 2-bit digit index cycles 0,1,2,3,0... one step per clock whenever an owner exists.
REQ-019 Each cycle in OWNi, the nibble data_i[4k+3:4k] and dp_i[k] for current index k are decoded and registered into hexk; other hex outputs hold.
REQ-020 Encoding: dp lit -> bit7 = 0; 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E; a full refresh of all four digits takes 4 cycles.
REQ-021 The digit index resets to 0 on every grant change, so hex0 refreshes in the first cycle after the grant, hex3 in the fourth.
REQ-022 Entering IDLE forces hex3..hex0 to 8'hFF (blank) on the same edge that clears gnt.
REQ-023 data and dp are sampled live (not latched at grant); a change is visible on a digit within 4 cycles.
REQ-024 Direct handoff OWNi -> OWN(1-i) does not blank; digits show the old owner's data until each is refreshed.

Reset
REQ-025 reset high at any edge, including mid-ownership or mid-refresh: next state is IDLE, gnt = 00, busy = 0, hex3..hex0 = 8'hFF, counter = 0, digit index = 0, pointer favours requester 0.
REQ-026 reset has priority over all req activity; the first grant can occur on the edge after the first edge on which reset is low.

Verification
REQ-027 Reset, then req = 01 with data0 = 16'h1234 and dp0 = 0: gnt = 01 after 1 cycle; after 4 more cycles hex0 = 8'h99 (4), hex1 = 8'hB0 (3), hex2 = 8'hA4 (2), hex3 = 8'hF9 (1).
REQ-028 HOLD_CYCLES = 4, req = 11 from IDLE after reset: gnt = 01; after 4 cycles in OWN0, gnt = 10; after 4 more cycles, gnt = 01 again.
REQ-029 OWN0 with req changed to 10 at counter = 1: gnt = 10 on the next edge, with no IDLE cycle and no blank outputs.
REQ-030 OWN1, req drops to 00: next cycle gnt = 00, busy = 0, all hex = 8'hFF.
REQ-031 reset pulsed mid-refresh in OWN1: all outputs match REQ-025 on the next edge; later req = 11 grants requester 0 first.
REQ-032 data0 = 16'h0008 with dp0 = 4'b0001: hex0 = 8'h00 after refresh; data0 changed to 16'h000F mid-ownership: hex0 = 8'h0E within 4 cycles.
